// File: rtl/spi_flash_rd_ctrl_if.sv
// Request/response bus between a read client and the SPI flash read controller.
interface spi_flash_rd_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic [23:0] req_addr;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;

    modport master (
        output req_valid, req_addr, rsp_ready,
        input  req_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  req_valid, req_addr, rsp_ready,
        output req_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/spi_flash_rd_ctrl.sv
// SPI mode-0 NOR read controller: one 24-bit address in, one little-endian 32-bit word out.
// Optional macro SPI_FAST_READ_EN selects FAST READ (0x0B + 8 dummy clocks) instead of READ (0x03).
module spi_flash_rd_ctrl #(
    parameter int unsigned CLK_DIV     = 2,
    parameter int unsigned CS_HIGH_CYC = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    spi_flash_rd_ctrl_if.slave        bus,
    output logic                      busy_o,
    output logic                      spi_cs_n_o,
    output logic                      spi_sck_o,
    output logic                      spi_mosi_o,
    input  logic                      spi_miso_i,
    output logic                      spi_wp_n_o,
    output logic                      spi_hold_n_o
);

`ifdef SPI_FAST_READ_EN
    localparam logic [7:0]  CMD   = 8'h0B;
    localparam int unsigned NBITS = 72;
`else
    localparam logic [7:0]  CMD   = 8'h03;
    localparam int unsigned NBITS = 64;
`endif
    localparam int unsigned DATA_START = NBITS - 32;

    typedef enum logic [2:0] {IDLE, SHIFT, CS_HOLD, RESP, CS_GAP} state_t;

    state_t      state_q, state_d;
    logic [7:0]  div_q, div_d;
    logic [6:0]  bit_q, bit_d;
    logic [7:0]  gap_q, gap_d;
    logic [31:0] sr_q, sr_d;
    logic [31:0] rx_q, rx_d;
    logic [31:0] rsp_data_q, rsp_data_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        cs_n_q, cs_n_d;
    logic        sck_q, sck_d;
    logic        mosi_q, mosi_d;
    logic        busy_q, busy_d;
    logic [4:0]  data_idx;

    // Bytes arrive MSB first but fill the word from the low byte upward.
    assign data_idx = 5'(bit_q - 7'(DATA_START));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= CS_GAP;
            div_q       <= '0;
            bit_q       <= '0;
            gap_q       <= '0;
            sr_q        <= '0;
            rx_q        <= '0;
            rsp_data_q  <= '0;
            rsp_valid_q <= 1'b0;
            cs_n_q      <= 1'b1;
            sck_q       <= 1'b0;
            mosi_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            bit_q       <= bit_d;
            gap_q       <= gap_d;
            sr_q        <= sr_d;
            rx_q        <= rx_d;
            rsp_data_q  <= rsp_data_d;
            rsp_valid_q <= rsp_valid_d;
            cs_n_q      <= cs_n_d;
            sck_q       <= sck_d;
            mosi_q      <= mosi_d;
            busy_q      <= busy_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        bit_d       = bit_q;
        gap_d       = gap_q;
        sr_d        = sr_q;
        rx_d        = rx_q;
        rsp_data_d  = rsp_data_q;
        rsp_valid_d = rsp_valid_q;
        cs_n_d      = cs_n_q;
        sck_d       = sck_q;
        mosi_d      = mosi_q;
        busy_d      = busy_q;

        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    state_d = SHIFT;
                    sr_d    = {CMD, bus.req_addr};
                    mosi_d  = CMD[7];
                    cs_n_d  = 1'b0;
                    div_d   = '0;
                    bit_d   = '0;
                    rx_d    = '0;
                    busy_d  = 1'b1;
                end
            end
            SHIFT: begin
                if (div_q == 8'(CLK_DIV - 1)) begin
                    div_d = '0;
                    if (!sck_q) begin
                        sck_d = 1'b1;
                        if (bit_q >= 7'(DATA_START))
                            rx_d[{data_idx[4:3], ~data_idx[2:0]}] = spi_miso_i;
                    end else begin
                        // Zeros shift in behind the address, so MOSI idles low afterwards.
                        sck_d  = 1'b0;
                        sr_d   = {sr_q[30:0], 1'b0};
                        mosi_d = sr_q[30];
                        if (bit_q == 7'(NBITS - 1))
                            state_d = CS_HOLD;
                        else
                            bit_d = bit_q + 7'd1;
                    end
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            CS_HOLD: begin
                if (div_q == 8'(CLK_DIV - 1)) begin
                    div_d       = '0;
                    cs_n_d      = 1'b1;
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = rx_q;
                    state_d     = RESP;
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    gap_d       = '0;
                    state_d     = CS_GAP;
                end
            end
            CS_GAP: begin
                if (gap_q == 8'(CS_HIGH_CYC - 1)) begin
                    gap_d   = '0;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q + 8'd1;
                end
            end
            default: begin
                state_d = CS_GAP;
                gap_d   = '0;
            end
        endcase
    end

    assign bus.req_ready = (state_q == IDLE);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign busy_o        = busy_q;
    assign spi_cs_n_o    = cs_n_q;
    assign spi_sck_o     = sck_q;
    assign spi_mosi_o    = mosi_q;
    assign spi_wp_n_o    = 1'b1;
    assign spi_hold_n_o  = 1'b1;

endmodule

// File: tb/tb_spi_flash_rd_ctrl.sv
// Directed bench for spi_flash_rd_ctrl with a small behavioural flash on the SPI pins.
module tb_spi_flash_rd_ctrl;

    localparam int H  = 2;
    localparam int CS = 4;
`ifdef SPI_FAST_READ_EN
    localparam logic [7:0] CMD = 8'h0B;
    localparam int         NB  = 72;
`else
    localparam logic [7:0] CMD = 8'h03;
    localparam int         NB  = 64;
`endif
    localparam int DS  = NB - 32;
    localparam int LAT = 2 * H * NB + H;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy, spi_cs_n, spi_sck, spi_mosi, spi_miso, spi_wp_n, spi_hold_n;

    spi_flash_rd_ctrl_if bus ();

    spi_flash_rd_ctrl #(.CLK_DIV(H), .CS_HIGH_CYC(CS)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .busy_o       (busy),
        .spi_cs_n_o   (spi_cs_n),
        .spi_sck_o    (spi_sck),
        .spi_mosi_o   (spi_mosi),
        .spi_miso_i   (spi_miso),
        .spi_wp_n_o   (spi_wp_n),
        .spi_hold_n_o (spi_hold_n)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int acc_cyc, rsp_cyc, hs_cyc;

    always @(posedge clk) cyc <= cyc + 1;

    // Flash model: shifts out a new bit after every SCK fall, records what the host sent.
    logic [7:0]  flash_bytes [4];
    int          fall_cnt = 0;
    int          rise_cnt = 0;
    int          miso_d;
    logic [31:0] cap = '0;
    logic        mosi_hi = 1'b0;

    always @(negedge spi_sck or posedge spi_cs_n) begin
        if (spi_cs_n) fall_cnt <= 0;
        else          fall_cnt <= fall_cnt + 1;
    end

    always @(posedge spi_sck or negedge spi_cs_n) begin
        if (spi_sck) begin
            if (rise_cnt < 32) cap <= {cap[30:0], spi_mosi};
            else if (spi_mosi) mosi_hi <= 1'b1;
            rise_cnt <= rise_cnt + 1;
        end else begin
            rise_cnt <= 0;
            cap      <= '0;
            mosi_hi  <= 1'b0;
        end
    end

    always_comb begin
        miso_d   = fall_cnt - DS;
        spi_miso = 1'b1;
        if (miso_d >= 0 && miso_d < 32)
            spi_miso = flash_bytes[miso_d / 8][7 - (miso_d % 8)];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_bytes(input logic [7:0] b0, b1, b2, b3);
        flash_bytes[0] = b0;
        flash_bytes[1] = b1;
        flash_bytes[2] = b2;
        flash_bytes[3] = b3;
    endtask

    task automatic start_req(input logic [23:0] a, input bit hold);
        int w;
        w = 0;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_addr  = a;
        while (!bus.req_ready && w < 600) begin
            @(negedge clk);
            w++;
        end
        chk("req_ready_seen", bus.req_ready, 1);
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        chk("cs_low_after_accept", spi_cs_n, 0);
        if (!hold) bus.req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input logic [23:0] a, input logic [31:0] d, input string tag);
        int n;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!bus.rsp_valid && n < 600);
        rsp_cyc = cyc;
        chk({tag, "_latency"}, n, LAT);
        chk({tag, "_data"}, bus.rsp_data, d);
        chk({tag, "_cs_high"}, spi_cs_n, 1);
        chk({tag, "_mosi_cmd_addr"}, cap, {CMD, a});
        chk({tag, "_sck_count"}, rise_cnt, NB);
        chk({tag, "_mosi_low_after_addr"}, mosi_hi, 0);
    endtask

    initial begin
        bit stable, never_valid;
        logic [31:0] held;
        int w;
        bus.req_valid = 1'b0;
        bus.req_addr  = '0;
        bus.rsp_ready = 1'b0;
        set_bytes(8'h00, 8'h00, 8'h00, 8'h00);

        // Reset values
        #12;
        chk("rst_cs_n", spi_cs_n, 1);
        chk("rst_sck", spi_sck, 0);
        chk("rst_mosi", spi_mosi, 0);
        chk("rst_req_ready", bus.req_ready, 0);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_rsp_data", bus.rsp_data, 0);
        chk("rst_busy", busy, 0);
        chk("wp_n", spi_wp_n, 1);
        chk("hold_n", spi_hold_n, 1);

        @(negedge clk);
        rst = 1'b0;
        repeat (CS - 1) @(posedge clk);
        #1;
        chk("req_ready_before_gap", bus.req_ready, 0);
        @(posedge clk);
        #1;
        chk("req_ready_after_gap", bus.req_ready, 1);

        // Basic read
        set_bytes(8'hEF, 8'hBE, 8'hAD, 8'hDE);
        start_req(24'h012345, 1'b0);
        chk("busy_in_shift", busy, 1);
        wait_rsp(24'h012345, 32'hDEADBEEF, "rd1");

        // Consumer stall
        held   = bus.rsp_data;
        stable = 1'b1;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (!bus.rsp_valid || bus.rsp_data !== held || !spi_cs_n || bus.req_ready) stable = 1'b0;
        end
        chk("stall_stable", stable, 1);
        @(negedge clk);
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        hs_cyc = cyc;
        chk("rsp_valid_dropped", bus.rsp_valid, 0);
        chk("busy_in_gap", busy, 1);

        // Back-to-back with req_valid held high and rsp_ready held high
        set_bytes(8'h11, 8'h22, 8'h33, 8'h44);
        start_req(24'h000000, 1'b1);
        chk("gap_after_handshake_ge4", (acc_cyc - hs_cyc) >= CS, 1);
        wait_rsp(24'h000000, 32'h44332211, "rd2");
        set_bytes(8'hA5, 8'h5A, 8'hC3, 8'h3C);
        start_req(24'hFFFFFC, 1'b0);
        chk("cs_high_between_ge4", (acc_cyc - rsp_cyc) >= CS, 1);
        wait_rsp(24'hFFFFFC, 32'h3CC35AA5, "rd3");
        @(posedge clk);
        #1;
        chk("rd3_handshake", bus.rsp_valid, 0);
        bus.rsp_ready = 1'b0;

        // Reset in the middle of the data phase
        set_bytes(8'h01, 8'h02, 8'h03, 8'h04);
        start_req(24'h000100, 1'b0);
        w = 0;
        while (rise_cnt < 40 && w < 600) begin
            @(posedge clk);
            w++;
        end
        chk("reached_bit40", rise_cnt >= 40, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_cs_n", spi_cs_n, 1);
        chk("midrst_sck", spi_sck, 0);
        chk("midrst_busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;
        never_valid = 1'b1;
        repeat (300) begin
            @(posedge clk);
            #1;
            if (bus.rsp_valid) never_valid = 1'b0;
        end
        chk("midrst_no_rsp", never_valid, 1);

        set_bytes(8'hDE, 8'hBC, 8'h9A, 8'h78);
        start_req(24'h0ABCDE, 1'b0);
        wait_rsp(24'h0ABCDE, 32'h789ABCDE, "rd4");
        @(negedge clk);
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("rd4_handshake", bus.rsp_valid, 0);
        bus.rsp_ready = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
